// File: rtl/cpu_pkg.sv
// Shared datapath encodings and types for the memory access stage.
// Imported by the stage, its stack pointer and its memory bus interface.
package cpu_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] MADDR_ALUOUT = 2'b00;
    localparam logic [1:0] MADDR_PC     = 2'b01;
    localparam logic [1:0] MADDR_STACK  = 2'b10;
    localparam logic [1:0] MADDR_RD     = 2'b11;

    localparam logic MDIN_ALUOUT = 1'b0;
    localparam logic MDIN_BDATA  = 1'b1;

    localparam logic PUSH = 1'b0;
    localparam logic POP  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the memory access stage and memory.
// The stage is the master; memory answers with a one-cycle ack.
interface mem_access_unit_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_access_unit_stack_pointer.sv
// Stack pointer register with push/pop address and next-value arithmetic.
// Push pre-decrements, pop post-increments; both wrap mod 2^WIDTH.
module stack_pointer
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = DATA_W,
    parameter logic [WIDTH-1:0] SP_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op,
    input  logic             commit,
    input  logic [WIDTH-1:0] commit_sp,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] stack_addr,
    output logic [WIDTH-1:0] next_sp
);

    always_comb begin
        stack_addr = sp;
        next_sp    = sp;
        unique case (op)
            PUSH: begin
                stack_addr = sp - WIDTH'(1);
                next_sp    = sp - WIDTH'(1);
            end
            POP: begin
                stack_addr = sp;
                next_sp    = sp + WIDTH'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= SP_RESET;
        end else if (commit) begin
            sp <= commit_sp;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: selects address/data, runs the req/ack access,
// latches read data into MDR and commits stack pointer updates.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = DATA_W,
    parameter logic [WIDTH-1:0] SP_RESET = '0,
    parameter int               TIMEOUT  = 255
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             MRead,
    input  logic             MWrite,
    input  logic [1:0]       MAddr,
    input  logic             MDin,
    input  logic             PshPop,
    input  logic             SPWrite,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic [WIDTH-1:0] RdData,
    input  logic [WIDTH-1:0] BData,
    mem_access_unit_if.master mem,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] SP,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    logic [7:0]       wait_cnt;
    logic             is_read;
    logic             sp_wr;
    logic [WIDTH-1:0] new_sp;
    logic [WIDTH-1:0] stack_addr;
    logic [WIDTH-1:0] next_sp;
    logic [WIDTH-1:0] addr_sel;
    logic [WIDTH-1:0] wdata_sel;
    logic             sp_commit;

    stack_pointer #(
        .WIDTH    (WIDTH),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk        (CLK),
        .rst        (Reset),
        .op         (PshPop),
        .commit     (sp_commit),
        .commit_sp  (new_sp),
        .sp         (SP),
        .stack_addr (stack_addr),
        .next_sp    (next_sp)
    );

    always_comb begin
        addr_sel = ALUOut;
        unique case (MAddr)
            MADDR_ALUOUT: addr_sel = ALUOut;
            MADDR_PC:     addr_sel = PC;
            MADDR_STACK:  addr_sel = stack_addr;
            MADDR_RD:     addr_sel = RdData;
        endcase
    end

    always_comb begin
        wdata_sel = ALUOut;
        unique case (MDin)
            MDIN_ALUOUT: wdata_sel = ALUOut;
            MDIN_BDATA:  wdata_sel = BData;
        endcase
    end

    // SP only moves on a real ack; timeouts and resets leave it alone
    assign sp_commit = (state == ACCESS) && mem.ack && sp_wr;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            is_read   <= 1'b0;
            sp_wr     <= 1'b0;
            new_sp    <= '0;
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            MDR       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (MRead || MWrite) begin
                        state     <= ACCESS;
                        wait_cnt  <= '0;
                        is_read   <= !MWrite;
                        sp_wr     <= SPWrite && (MAddr == MADDR_STACK);
                        new_sp    <= next_sp;
                        mem.req   <= 1'b1;
                        mem.we    <= MWrite;
                        mem.addr  <= addr_sel;
                        mem.wdata <= wdata_sel;
                        Busy      <= 1'b1;
                        if (MRead && MWrite) begin
                            Err <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem.ack) begin
                        if (is_read) begin
                            MDR <= mem.rdata;
                        end
                        state   <= DONE;
                        mem.req <= 1'b0;
                        mem.we  <= 1'b0;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= DONE;
                        mem.req <= 1'b0;
                        mem.we  <= 1'b0;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses against a
// variable-latency memory responder, checked when Done pulses.
module tb_mem_access_unit;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdr;
        logic [15:0] sp;
        logic        we;
        logic        err;
        logic        chk_w;
        int          busy;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        MRead = 1'b0;
    logic        MWrite = 1'b0;
    logic [1:0]  MAddr = 2'b00;
    logic        MDin = 1'b0;
    logic        PshPop = 1'b0;
    logic        SPWrite = 1'b0;
    logic [15:0] PC = '0;
    logic [15:0] ALUOut = '0;
    logic [15:0] RdData = '0;
    logic [15:0] BData = '0;
    logic [15:0] MDR;
    logic [15:0] SP;
    logic        Busy;
    logic        Done;
    logic        Err;

    mem_access_unit_if #(.WIDTH(16)) mem ();

    mem_access_unit #(
        .WIDTH    (16),
        .SP_RESET (16'h0000),
        .TIMEOUT  (255)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .MRead   (MRead),
        .MWrite  (MWrite),
        .MAddr   (MAddr),
        .MDin    (MDin),
        .PshPop  (PshPop),
        .SPWrite (SPWrite),
        .PC      (PC),
        .ALUOut  (ALUOut),
        .RdData  (RdData),
        .BData   (BData),
        .mem     (mem.master),
        .MDR     (MDR),
        .SP      (SP),
        .Busy    (Busy),
        .Done    (Done),
        .Err     (Err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    int          ack_wait = 0;
    logic [15:0] rd_val = '0;
    int          late_req = 0;
    int          req_rises = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // memory model: ack after ack_wait idle request cycles, -1 never acks
    initial begin
        int wcnt;
        int late_done;
        wcnt = 0;
        late_done = 0;
        mem.ack = 1'b0;
        mem.rdata = '0;
        forever begin
            @(negedge CLK);
            if (mem.ack) begin
                mem.ack = 1'b0;
                wcnt = 0;
            end else if (late_req != late_done) begin
                mem.ack = 1'b1;
                mem.rdata = rd_val;
                late_done = late_req;
            end else if (mem.req) begin
                if (wcnt == ack_wait) begin
                    mem.ack = 1'b1;
                    mem.rdata = rd_val;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // monitor: capture bus values while requesting, score on Done
    initial begin
        logic [15:0] cap_addr;
        logic [15:0] cap_wdata;
        logic        cap_we;
        logic        prev_req;
        int          bcnt;
        exp_t        e;
        cap_addr = '0;
        cap_wdata = '0;
        cap_we = 1'b0;
        prev_req = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge CLK);
            if (mem.req && !prev_req) req_rises++;
            prev_req = mem.req;
            if (mem.req) begin
                cap_addr = mem.addr;
                cap_wdata = mem.wdata;
                cap_we = mem.we;
            end
            if (Busy) bcnt++;
            if (Done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    chk("mem_addr", 32'(cap_addr), 32'(e.addr));
                    chk("mem_we", 32'(cap_we), 32'(e.we));
                    if (e.chk_w) chk("mem_wdata", 32'(cap_wdata), 32'(e.wdata));
                    chk("mdr", 32'(MDR), 32'(e.mdr));
                    chk("sp", 32'(SP), 32'(e.sp));
                    chk("err", 32'(Err), 32'(e.err));
                    chk("busy_cycles", 32'(bcnt), 32'(e.busy));
                end
                bcnt = 0;
            end else if (!Busy) begin
                bcnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while ((Busy || Done || q.size() != 0) && n < 600) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] ma,
                         input logic md, input logic pp, input logic spw,
                         input int hold);
        MRead = rd;
        MWrite = wr;
        MAddr = ma;
        MDin = md;
        PshPop = pp;
        SPWrite = spw;
        repeat (hold) @(posedge CLK);
        #1;
        MRead = 1'b0;
        MWrite = 1'b0;
        SPWrite = 1'b0;
    endtask

    task automatic expect_acc(input logic [15:0] a, input logic w, input logic [15:0] wd,
                              input logic cw, input logic [15:0] m, input logic [15:0] s,
                              input logic er, input int b);
        exp_t e;
        e.addr = a;
        e.we = w;
        e.wdata = wd;
        e.chk_w = cw;
        e.mdr = m;
        e.sp = s;
        e.err = er;
        e.busy = b;
        q.push_back(e);
    endtask

    initial begin
        int rises0;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        chk("rst_req", 32'(mem.req), 32'd0);
        chk("rst_we", 32'(mem.we), 32'd0);
        chk("rst_addr", 32'(mem.addr), 32'd0);
        chk("rst_wdata", 32'(mem.wdata), 32'd0);
        chk("rst_mdr", 32'(MDR), 32'd0);
        chk("rst_sp", 32'(SP), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);

        // fetch read, 3 wait cycles
        wait_idle();
        PC = 16'h0010; ALUOut = 16'h1111;
        ack_wait = 3; rd_val = 16'hA5C3;
        expect_acc(16'h0010, 1'b0, 16'h0, 1'b0, 16'hA5C3, 16'h0000, 1'b0, 4);
        issue(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1);

        // store word via RdData, immediate ack
        wait_idle();
        RdData = 16'h0200; BData = 16'h1234;
        ack_wait = 0; rd_val = 16'hFFFF;
        expect_acc(16'h0200, 1'b1, 16'h1234, 1'b1, 16'hA5C3, 16'h0000, 1'b0, 1);
        issue(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1);

        // push wraps SP 0000 -> FFFF
        wait_idle();
        BData = 16'h00BE; ack_wait = 1;
        expect_acc(16'hFFFF, 1'b1, 16'h00BE, 1'b1, 16'hA5C3, 16'hFFFF, 1'b0, 2);
        issue(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1);

        // pop wraps SP FFFF -> 0000
        wait_idle();
        ack_wait = 0; rd_val = 16'h00BE;
        expect_acc(16'hFFFF, 1'b0, 16'h0, 1'b0, 16'h00BE, 16'h0000, 1'b0, 1);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1);

        // SPWrite on a non-stack address leaves SP alone
        wait_idle();
        ALUOut = 16'h0042; ack_wait = 2; rd_val = 16'h7777;
        expect_acc(16'h0042, 1'b0, 16'h0, 1'b0, 16'h7777, 16'h0000, 1'b0, 3);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1);

        // SPWrite with no access is ignored
        wait_idle();
        MAddr = 2'b10; PshPop = 1'b0; SPWrite = 1'b1;
        repeat (3) @(posedge CLK);
        #1 SPWrite = 1'b0;
        @(negedge CLK);
        chk("spwrite_idle_sp", 32'(SP), 32'h0000);
        chk("spwrite_idle_busy", 32'(Busy), 32'd0);

        // timeout: memory never answers
        wait_idle();
        PC = 16'h0020; ack_wait = -1; rd_val = 16'hDEAD;
        expect_acc(16'h0020, 1'b0, 16'h0, 1'b0, 16'h7777, 16'h0000, 1'b1, 255);
        issue(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1);

        // next command still accepted, Err sticky
        wait_idle();
        PC = 16'h0030; ack_wait = 0; rd_val = 16'h1357;
        expect_acc(16'h0030, 1'b0, 16'h0, 1'b0, 16'h1357, 16'h0000, 1'b1, 1);
        issue(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1);

        // reset during a push access, then a late ack
        wait_idle();
        BData = 16'hBEEF; ack_wait = -1; rd_val = 16'h4321;
        issue(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1);
        repeat (3) @(negedge CLK);
        chk("mid_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        chk("mid_rst_req", 32'(mem.req), 32'd0);
        chk("mid_rst_sp", 32'(SP), 32'h0000);
        chk("mid_rst_mdr", 32'(MDR), 32'h0000);
        chk("mid_rst_err", 32'(Err), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        late_req++;
        repeat (4) @(negedge CLK);
        chk("late_ack_mdr", 32'(MDR), 32'h0000);
        chk("late_ack_sp", 32'(SP), 32'h0000);
        chk("late_ack_req", 32'(mem.req), 32'd0);

        // read+write together -> write with Err; MRead held while busy
        wait_idle();
        rises0 = req_rises;
        ALUOut = 16'h0055; ack_wait = 3; rd_val = 16'h9999;
        expect_acc(16'h0055, 1'b1, 16'h0055, 1'b1, 16'h0000, 16'h0000, 1'b1, 4);
        MWrite = 1'b1;
        issue(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1);
        MRead = 1'b1;
        repeat (2) @(posedge CLK);
        #1 MRead = 1'b0;
        wait_idle();
        chk("single_req", 32'(req_rises - rises0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
